// File: rtl/iso14443a_resend_buffer_pkg.sv
// Shared types and constants for the ISO/IEC 14443-4A resend buffer.
// Holds the controller state encoding and the pointer width helper.
package ISO14443A_pkg;

    localparam int RESEND_BUFFER_DEFAULT_DEPTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PASS   = 2'd1,
        ST_REPLAY = 2'd2
    } resend_state_e;

    // Pointers and the stored length must be able to hold the value DEPTH itself.
    function automatic int ptr_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/iso14443a_resend_buffer_byte_buffer.sv
// Plain byte storage for the last reply: one synchronous write port and
// one asynchronous read port, deliberately without reset.
module byte_buffer #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/iso14443a_resend_buffer.sv
// Passes the application reply through to the 14443-4A transmit path while
// recording it, so the previous reply can be replayed on a resend request.
module iso14443a_resend_buffer
    import ISO14443A_pkg::*;
#(
    parameter int DEPTH = RESEND_BUFFER_DEFAULT_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       app_tx_valid,
    input  logic [7:0] app_tx_data,
    input  logic       app_tx_last,
    output logic       app_tx_ready,
    input  logic       resend_last,
    input  logic       invalidate,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       replaying,
    output logic       stored_valid,
    output logic       resend_empty
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = $clog2(DEPTH);

    resend_state_e r_state;
    resend_state_e w_next_state;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_length;
    logic          r_ovf;
    logic          r_stored_valid;
    logic          r_resend_empty;

    logic          w_resend_hit;
    logic          w_app_fire;
    logic          w_out_fire;
    logic          w_first_byte;
    logic          w_commit;
    logic          w_wr_full;
    logic          w_store;
    logic          w_replay_last;
    logic [PW-1:0] w_wr_addr;
    logic [PW-1:0] w_wr_count;
    logic [7:0]    w_buf_rdata;

    // A resend seen in IDLE takes priority over a byte offered in the same cycle.
    assign w_resend_hit  = (r_state == ST_IDLE) && resend_last;
    assign w_app_fire    = app_tx_valid && app_tx_ready;
    assign w_out_fire    = out_valid && out_ready;
    assign w_first_byte  = w_app_fire && (r_state == ST_IDLE);
    assign w_commit      = w_app_fire && app_tx_last;
    assign w_wr_addr     = w_first_byte ? '0 : r_wr_ptr;
    assign w_wr_full     = (w_wr_addr == PW'(DEPTH));
    assign w_store       = w_app_fire && !w_wr_full;
    assign w_wr_count    = w_store ? (w_wr_addr + PW'(1)) : w_wr_addr;
    assign w_replay_last = (r_rd_ptr == (r_length - PW'(1)));

    byte_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_byte_buffer (
        .clk     (clk),
        .i_we    (w_store),
        .i_waddr (w_wr_addr[AW-1:0]),
        .i_wdata (app_tx_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_buf_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_resend_hit && r_stored_valid) begin
                    w_next_state = ST_REPLAY;
                end else if (w_app_fire && !app_tx_last) begin
                    w_next_state = ST_PASS;
                end
            end
            ST_PASS: begin
                if (w_commit) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_REPLAY: begin
                if (w_out_fire && w_replay_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        app_tx_ready = 1'b0;
        out_valid    = 1'b0;
        out_data     = app_tx_data;
        out_last     = app_tx_last;
        replaying    = 1'b0;
        if (r_state == ST_REPLAY) begin
            out_valid = 1'b1;
            out_data  = w_buf_rdata;
            out_last  = w_replay_last;
            replaying = 1'b1;
        end else begin
            app_tx_ready = out_ready && !w_resend_hit;
            out_valid    = app_tx_valid && !w_resend_hit;
        end
    end

    // Later assignments win: commit overrides the first-byte clear, invalidate overrides both.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_length       <= '0;
            r_ovf          <= 1'b0;
            r_stored_valid <= 1'b0;
            r_resend_empty <= 1'b0;
        end else begin
            r_resend_empty <= w_resend_hit && !r_stored_valid;
            if (w_app_fire) begin
                r_wr_ptr <= w_wr_count;
                if (w_wr_full) begin
                    r_ovf <= 1'b1;
                end
            end
            if (w_first_byte) begin
                r_stored_valid <= 1'b0;
            end
            if (w_commit) begin
                r_length       <= w_wr_count;
                r_stored_valid <= !(r_ovf || w_wr_full);
                r_ovf          <= 1'b0;
            end
            if (invalidate) begin
                r_stored_valid <= 1'b0;
            end
            if (w_resend_hit && r_stored_valid) begin
                r_rd_ptr <= '0;
            end else if ((r_state == ST_REPLAY) && w_out_fire) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    assign stored_valid = r_stored_valid;
    assign resend_empty = r_resend_empty;

endmodule

// File: tb/tb_iso14443a_resend_buffer.sv
// Self-checking bench for the resend buffer: directed scenarios followed by
// randomized messages, checked against a queue-based model of the stored reply.
module tb_iso14443a_resend_buffer;

    localparam int DEPTH = 32;

    logic       clk;
    logic       rst;
    logic       app_tx_valid;
    logic [7:0] app_tx_data;
    logic       app_tx_last;
    logic       app_tx_ready;
    logic       resend_last;
    logic       invalidate;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       replaying;
    logic       stored_valid;
    logic       resend_empty;

    logic       sValid;
    logic [7:0] sData;
    logic       sLast;
    logic       sReady;
    logic       sResend;
    logic       sInvalidate;
    logic       sOutValid;
    logic [7:0] sOutData;
    logic       sOutLast;
    logic       sOutReady;
    logic       sReplaying;
    logic       sStored;
    logic       sEmpty;

    int total = 0;
    int bad   = 0;

    logic [7:0] modelStored[$];
    bit         modelValid = 1'b0;

    iso14443a_resend_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .app_tx_valid (app_tx_valid),
        .app_tx_data  (app_tx_data),
        .app_tx_last  (app_tx_last),
        .app_tx_ready (app_tx_ready),
        .resend_last  (resend_last),
        .invalidate   (invalidate),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .replaying    (replaying),
        .stored_valid (stored_valid),
        .resend_empty (resend_empty)
    );

    iso14443a_resend_buffer #(.DEPTH(4)) dutSmall (
        .clk          (clk),
        .rst          (rst),
        .app_tx_valid (sValid),
        .app_tx_data  (sData),
        .app_tx_last  (sLast),
        .app_tx_ready (sReady),
        .resend_last  (sResend),
        .invalidate   (sInvalidate),
        .out_valid    (sOutValid),
        .out_data     (sOutData),
        .out_last     (sOutLast),
        .out_ready    (sOutReady),
        .replaying    (sReplaying),
        .stored_valid (sStored),
        .resend_empty (sEmpty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one application message; readyMode 0=toggling, 1=random gaps, 2=always ready.
    task automatic applyStimulus(input logic [7:0] msg[$], input int readyMode, input bit invOnLast);
        int idx = 0;
        int cycles = 0;
        bit phase = 1'b0;
        int n = msg.size();
        while (idx < n && cycles < 400) begin
            app_tx_valid = (readyMode == 1) ? 1'($urandom_range(0, 3) != 0) : 1'b1;
            app_tx_data  = msg[idx];
            app_tx_last  = (idx == n - 1);
            out_ready    = (readyMode == 0) ? phase : (readyMode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            phase        = !phase;
            resend_last  = (readyMode == 1 && idx > 0) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            invalidate   = invOnLast && (idx == n - 1);
            @(negedge clk);
            checkOutput("pass_valid", out_valid, app_tx_valid);
            if (app_tx_valid) begin
                checkOutput("pass_data", out_data, msg[idx]);
                checkOutput("pass_last", out_last, idx == n - 1);
            end
            checkOutput("pass_ready", app_tx_ready, out_ready);
            if (idx > 0) checkOutput("pass_stored_cleared", stored_valid, 0);
            if (app_tx_valid && out_ready) idx++;
            nextCycle();
            cycles++;
        end
        app_tx_valid = 1'b0;
        app_tx_last  = 1'b0;
        resend_last  = 1'b0;
        invalidate   = 1'b0;
        checkOutput("pass_done", idx, n);
        modelStored = msg;
        modelValid  = (n <= DEPTH) && !invOnLast;
        @(negedge clk);
        checkOutput("pass_stored", stored_valid, modelValid);
        checkOutput("pass_idle", replaying, 0);
        nextCycle();
    endtask

    // mode 0=plain replay, 1=collision with an app byte, 2=invalidate at abortIdx, 3=reset at abortIdx.
    task automatic requestResend(input int mode, input int abortIdx);
        int k = 0;
        int cycles = 0;
        int n = modelStored.size();
        logic [7:0] pending = 8'($urandom_range(0, 255));
        resend_last = 1'b1;
        invalidate  = 1'b0;
        out_ready   = 1'($urandom_range(0, 1));
        if (mode == 1) begin
            app_tx_valid = 1'b1;
            app_tx_data  = pending;
            app_tx_last  = 1'b1;
        end
        @(negedge clk);
        checkOutput("resend_ready", app_tx_ready, 0);
        checkOutput("resend_valid", out_valid, 0);
        nextCycle();
        resend_last = 1'b0;
        if (!modelValid) begin
            @(negedge clk);
            checkOutput("empty_pulse", resend_empty, 1);
            checkOutput("empty_out", out_valid, 0);
            checkOutput("empty_replaying", replaying, 0);
            nextCycle();
            @(negedge clk);
            checkOutput("empty_single", resend_empty, 0);
            nextCycle();
            return;
        end
        while (k < n && cycles < 400) begin
            out_ready   = 1'($urandom_range(0, 1));
            resend_last = 1'($urandom_range(0, 3) == 0);
            invalidate  = (mode == 2 && k == abortIdx);
            rst         = (mode == 3 && k == abortIdx);
            @(negedge clk);
            checkOutput("replay_valid", out_valid, 1);
            checkOutput("replay_data", out_data, modelStored[k]);
            checkOutput("replay_last", out_last, k == n - 1);
            checkOutput("replay_flag", replaying, 1);
            checkOutput("replay_app_ready", app_tx_ready, 0);
            if (rst) break;
            if (out_ready) k++;
            nextCycle();
            cycles++;
        end
        if (mode == 3) begin
            nextCycle();
            rst          = 1'b0;
            resend_last  = 1'b0;
            app_tx_valid = 1'b1;
            app_tx_data  = pending;
            app_tx_last  = 1'b0;
            out_ready    = 1'b0;
            modelValid   = 1'b0;
            @(negedge clk);
            checkOutput("rst_replaying", replaying, 0);
            checkOutput("rst_stored", stored_valid, 0);
            checkOutput("rst_out_valid", out_valid, 1);
            checkOutput("rst_out_data", out_data, pending);
            checkOutput("rst_app_ready", app_tx_ready, 0);
            app_tx_valid = 1'b0;
            nextCycle();
            return;
        end
        resend_last = 1'b0;
        invalidate  = 1'b0;
        checkOutput("replay_done", k, n);
        if (mode == 2) modelValid = 1'b0;
        if (mode == 1) begin
            out_ready = 1'b1;
            @(negedge clk);
            checkOutput("collide_valid", out_valid, 1);
            checkOutput("collide_data", out_data, pending);
            checkOutput("collide_ready", app_tx_ready, 1);
            checkOutput("collide_replaying", replaying, 0);
            nextCycle();
            app_tx_valid = 1'b0;
            app_tx_last  = 1'b0;
            modelStored  = {pending};
            modelValid   = 1'b1;
        end
        @(negedge clk);
        checkOutput("after_replaying", replaying, 0);
        checkOutput("after_stored", stored_valid, modelValid);
        nextCycle();
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] qs[$];
        int len;

        rst = 1'b1;
        app_tx_valid = 1'b0; app_tx_data = 8'h00; app_tx_last = 1'b0;
        resend_last = 1'b0; invalidate = 1'b0; out_ready = 1'b0;
        sValid = 1'b0; sData = 8'h00; sLast = 1'b0; sResend = 1'b0;
        sInvalidate = 1'b0; sOutReady = 1'b1;
        repeat (2) nextCycle();

        $display("[TB] reset checks");
        @(negedge clk);
        checkOutput("reset_stored", stored_valid, 0);
        checkOutput("reset_replaying", replaying, 0);
        checkOutput("reset_empty", resend_empty, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        nextCycle();
        rst = 1'b0;
        app_tx_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("oor_out_valid", out_valid, 1);
        checkOutput("oor_app_ready", app_tx_ready, 0);
        app_tx_valid = 1'b0;
        nextCycle();

        $display("[TB] pass-through and replay of the 5-byte reply");
        q = {8'h0A, 8'h01, 8'h90, 8'h00, 8'h11};
        applyStimulus(q, 0, 1'b0);
        requestResend(0, 0);

        $display("[TB] collision of resend and application byte");
        requestResend(1, 0);
        requestResend(0, 0);

        $display("[TB] invalidate during replay");
        applyStimulus(q, 2, 1'b0);
        requestResend(2, 1);
        requestResend(0, 0);

        $display("[TB] invalidate together with the last-byte commit");
        applyStimulus(q, 1, 1'b1);
        requestResend(0, 0);

        $display("[TB] reset on byte 3 of a replay");
        applyStimulus(q, 2, 1'b0);
        requestResend(3, 2);
        requestResend(0, 0);

        $display("[TB] capacity boundary");
        for (int extra = 0; extra < 2; extra++) begin
            q.delete();
            for (int b = 0; b < DEPTH + extra; b++) q.push_back(8'($urandom_range(0, 255)));
            applyStimulus(q, 2, 1'b0);
            requestResend(0, 0);
        end

        $display("[TB] randomized messages");
        for (int it = 0; it < 20; it++) begin
            len = $urandom_range(1, DEPTH + 3);
            q.delete();
            for (int b = 0; b < len; b++) q.push_back(8'($urandom_range(0, 255)));
            applyStimulus(q, $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
            if (modelValid) requestResend($urandom_range(0, 2), $urandom_range(0, len - 1));
            else requestResend(0, 0);
        end

        $display("[TB] small instance: exact fit then overflow");
        qs.delete();
        for (int b = 0; b < 4; b++) qs.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 4; i++) begin
            sValid = 1'b1; sData = qs[i]; sLast = (i == 3);
            @(negedge clk);
            checkOutput("fit_ready", sReady, 1);
            nextCycle();
        end
        sValid = 1'b0; sLast = 1'b0;
        @(negedge clk);
        checkOutput("fit_stored", sStored, 1);
        sResend = 1'b1;
        nextCycle();
        sResend = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("fit_replay_valid", sOutValid, 1);
            checkOutput("fit_replay_data", sOutData, qs[i]);
            checkOutput("fit_replay_last", sOutLast, i == 3);
            checkOutput("fit_replaying", sReplaying, 1);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("fit_done", sReplaying, 0);

        qs.delete();
        for (int b = 0; b < 6; b++) qs.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 6; i++) begin
            sValid = 1'b1; sData = qs[i]; sLast = (i == 5);
            @(negedge clk);
            checkOutput("ovf_valid", sOutValid, 1);
            checkOutput("ovf_data", sOutData, qs[i]);
            checkOutput("ovf_last", sOutLast, i == 5);
            nextCycle();
        end
        sValid = 1'b0; sLast = 1'b0;
        @(negedge clk);
        checkOutput("ovf_stored", sStored, 0);
        sResend = 1'b1;
        nextCycle();
        sResend = 1'b0;
        @(negedge clk);
        checkOutput("ovf_empty", sEmpty, 1);
        checkOutput("ovf_out_idle", sOutValid, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("ovf_empty_single", sEmpty, 0);
        checkOutput("ovf_still_idle", sOutValid, 0);
        nextCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iso14443a_resend_buffer.md
ISO14443A_RESEND_BUFFER -- requirements
Module: iso14443a_resend_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning the maximum reply length in bytes that can be stored for replay (range 2..256).
REQ-002 SHALL have port clk, input, 1, the 13.56MHz recovered clock; the block's only clock.
REQ-003 SHALL have port rst, input, 1, reset; synchronous to clk and active-high.
REQ-004 SHALL have ports app_tx_valid, app_tx_data and app_tx_last, input, 1/8/1, the byte stream from the application.
REQ-005 SHALL have port app_tx_ready, output, 1, which accepts an application byte when it is high together with app_tx_valid.
REQ-006 SHALL have port resend_last, input, 1, a one-cycle request from the ISO/IEC 14443-4A layer to replay the previous reply.
REQ-007 SHALL have port invalidate, input, 1, a one-cycle pulse (DESELECT/RATS/HLTA) that discards the stored reply.
REQ-008 SHALL have ports out_valid, out_data and out_last, output, 1/8/1, the byte stream towards the 14443-4A transmit path.
REQ-009 SHALL have port out_ready, input, 1, which marks a downstream accept.
REQ-010 SHALL have port replaying, output, 1, high while in REPLAY.
REQ-011 SHALL have port stored_valid, output, 1, high when a complete reply is held.
REQ-012 SHALL have port resend_empty, output, 1, a one-cycle pulse when a resend is requested with nothing stored.

Function
REQ-013 SHALL implement the states IDLE, PASS and REPLAY.
REQ-014 In IDLE and PASS the block SHALL pass the application stream through combinationally: out_valid=app_tx_valid, out_data=app_tx_data, out_last=app_tx_last, app_tx_ready=out_ready.
REQ-015 SHALL move from IDLE to PASS on the first accepted application byte, and from PASS back to IDLE on the accepted byte that carries app_tx_last.
REQ-016 SHALL clear stored_valid on the first accepted byte of a new message (the old contents are being overwritten).
REQ-017 SHALL write each accepted byte to buffer location wr_ptr and increment wr_ptr; wr_ptr SHALL reset to 0 at the start of each message.
REQ-018 Overflow: a byte accepted while wr_ptr==DEPTH SHALL still be forwarded, SHALL NOT be stored, and SHALL set a sticky ovf flag.
REQ-019 On the accepted last byte, length SHALL be set to the number of bytes written, and stored_valid SHALL be set to !ovf in the next cycle; ovf SHALL clear at the same time.
REQ-020 If resend_last is sampled high in IDLE and stored_valid=1, the block SHALL enter REPLAY, and out_valid SHALL assert in the next cycle with buffer byte 0.
REQ-021 In REPLAY, app_tx_ready SHALL be 0; out_data SHALL be buf[rd_ptr], with rd_ptr advancing on each out handshake.
REQ-022 In REPLAY, out_last SHALL be high when rd_ptr==length-1; the handshake on that byte SHALL return the block to IDLE; stored_valid SHALL remain 1.
REQ-023 out_data, out_last and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 If resend_last is sampled high in IDLE with stored_valid=0, resend_empty SHALL pulse for one cycle in the next cycle and the state SHALL stay IDLE.
REQ-025 resend_last sampled in PASS or REPLAY SHALL be ignored.
REQ-026 Simultaneous resend_last and app_tx_valid in IDLE: the resend SHALL win; app_tx_ready=0 that cycle and the application byte SHALL be held off.
REQ-027 invalidate SHALL clear stored_valid in the next cycle in any state; an in-progress REPLAY SHALL run to completion.
REQ-028 invalidate and a last-byte commit in the same cycle: invalidate SHALL win, so stored_valid=0.

Reset
REQ-029 While rst=1 the state SHALL be IDLE, and wr_ptr, rd_ptr, length, ovf, stored_valid, resend_empty and replaying SHALL all be 0.
REQ-030 Reset mid-PASS or mid-REPLAY SHALL abort the transfer; buffer contents need no reset.
REQ-031 Out of reset: out_valid SHALL equal app_tx_valid, and app_tx_ready SHALL equal out_ready.

Structure
REQ-032 The state enum and the constant RESEND_BUFFER_DEFAULT_DEPTH SHALL live in ISO14443A_pkg.
REQ-033 Storage SHALL be a sub-module named byte_buffer: parameterised by DEPTH, one write port and one asynchronous read port, no reset.
REQ-034 Pointer and length widths SHALL be $clog2(DEPTH+1).

Verification
REQ-035 Pass-through: a 5-byte reply 0x0A 0x01 0x90 0x00 0x11 with out_ready toggling each cycle -> identical bytes at out, last on 0x11, stored_valid=1 afterwards.
REQ-036 Replay: after REQ-035, pulse resend_last -> out_valid in the next cycle, 0x0A..0x11 replayed with last on 0x11, replaying high throughout, app_tx_ready=0.
REQ-037 Overflow: DEPTH=4, send a 6-byte reply -> all 6 bytes forwarded, stored_valid=0; a following resend_last -> resend_empty pulse, out_valid stays 0.
REQ-038 Collision: resend_last and app_tx_valid in the same IDLE cycle -> replay first; the application byte is accepted after the replay's last handshake.
REQ-039 Invalidate: invalidate during REPLAY -> replay completes, stored_valid=0; the next resend_last -> resend_empty.
REQ-040 Reset: rst asserted on byte 3 of a replay -> IDLE, stored_valid=0, out_valid follows app_tx_valid in the next cycle.
